// File: rtl/mixed_width_dp_bram_if.sv
// Bus interface for mixed_width_dp_bram: narrow port A, wide port B and
// the shared status outputs. The slave modport is the RAM side and the
// master modport is the requester side.
interface mixed_width_dp_bram_if #(
    parameter int AWidth = 8,
    parameter int Ratio  = 4,
    parameter int Depth  = 1024
);
    localparam int BWidth = AWidth * Ratio;
    localparam int AAW    = $clog2(Depth) + 1;
    localparam int BAW    = $clog2(Depth / Ratio) + 1;

    logic              a_en_i;
    logic              a_write_en_i;
    logic [AAW-1:0]    a_addr_i;
    logic [AWidth-1:0] a_data_i;
    logic [AWidth-1:0] a_data_o;
    logic              a_valid_o;

    logic              b_en_i;
    logic              b_write_en_i;
    logic [BAW-1:0]    b_addr_i;
    logic [BWidth-1:0] b_data_i;
    logic [BWidth-1:0] b_data_o;
    logic              b_valid_o;

    logic              busy_o;
    logic              collision_o;
    logic              oob_o;

    modport slave (
        input  a_en_i, a_write_en_i, a_addr_i, a_data_i,
        input  b_en_i, b_write_en_i, b_addr_i, b_data_i,
        output a_data_o, a_valid_o, b_data_o, b_valid_o,
        output busy_o, collision_o, oob_o
    );

    modport master (
        output a_en_i, a_write_en_i, a_addr_i, a_data_i,
        output b_en_i, b_write_en_i, b_addr_i, b_data_i,
        input  a_data_o, a_valid_o, b_data_o, b_valid_o,
        input  busy_o, collision_o, oob_o
    );
endinterface

// File: rtl/mixed_width_dp_bram.sv
// Asymmetric true dual-port block RAM. Port A accesses AWidth-bit words,
// port B accesses Ratio consecutive A words at once (lane 0 = LSBs).
// Write-first within a port, read-first across ports, A wins its lane on
// a write/write collision. Out-of-range accesses are acknowledged but
// drop writes and return 0.
// Optional feature macro: MIXED_WIDTH_DP_BRAM_CLEAR_EN adds a post-reset
// sweep that zeroes every B word while busy_o is high.
module mixed_width_dp_bram #(
    parameter int AWidth      = 8,
    parameter int Ratio       = 4,
    parameter int Depth       = 1024,
    parameter int ReadLatency = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    mixed_width_dp_bram_if.slave  bus
);
    localparam int BWidth = AWidth * Ratio;
    localparam int BDepth = Depth / Ratio;
    localparam int AAW    = $clog2(Depth) + 1;
    localparam int BIW    = (BDepth > 1) ? $clog2(BDepth) : 1;

    logic [BWidth-1:0] mem_q [BDepth];
    logic              busy;

`ifdef MIXED_WIDTH_DP_BRAM_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_READY} state_e;
    state_e          state_q;
    logic [BIW-1:0]  clr_cnt_q;

    // Clear sweep: one B word per cycle, restarted from 0 by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == BIW'(BDepth - 1)) begin
                state_q <= ST_READY;
            end
        end
    end

    assign busy = (state_q == ST_CLEAR);
`else
    assign busy = 1'b0;
`endif

    assign bus.busy_o = busy;

    // Request decode
    logic           a_acc, a_oob, a_inr, a_wr;
    logic           b_acc, b_oob, b_inr, b_wr;
    logic [BIW-1:0] a_bidx, b_bidx;
    int             a_lane;
    logic           collision_d, oob_d;

    assign a_acc  = bus.a_en_i & ~busy;
    assign a_oob  = (bus.a_addr_i >= AAW'(Depth));
    assign a_inr  = a_acc & ~a_oob;
    assign a_wr   = a_inr & bus.a_write_en_i;
    assign a_bidx = BIW'(bus.a_addr_i / AAW'(Ratio));
    assign a_lane = int'(bus.a_addr_i % AAW'(Ratio));

    assign b_acc  = bus.b_en_i & ~busy;
    assign b_oob  = (bus.b_addr_i >= $bits(bus.b_addr_i)'(BDepth));
    assign b_inr  = b_acc & ~b_oob;
    assign b_wr   = b_inr & bus.b_write_en_i;
    assign b_bidx = bus.b_addr_i[BIW-1:0];

    // Out-of-range accesses are excluded from collisions by the in-range terms
    assign collision_d = a_inr & b_inr & (a_bidx == b_bidx)
                       & (bus.a_write_en_i | bus.b_write_en_i);
    assign oob_d       = (a_acc & a_oob) | (b_acc & b_oob);

    // Read data: own write echoes, otherwise pre-write memory contents
    logic [AWidth-1:0] a_rd_d;
    logic [BWidth-1:0] b_rd_d;

    always_comb begin
        a_rd_d = '0;
        b_rd_d = '0;
        if (a_inr) begin
            a_rd_d = bus.a_write_en_i ? bus.a_data_i
                                      : mem_q[a_bidx][a_lane*AWidth +: AWidth];
        end
        if (b_inr) begin
            b_rd_d = bus.b_write_en_i ? bus.b_data_i : mem_q[b_bidx];
        end
    end

    // Memory writes: B word first, then A lane so A wins its lane
    always_ff @(posedge clk_i) begin
`ifdef MIXED_WIDTH_DP_BRAM_CLEAR_EN
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end
`endif
        if (b_wr) begin
            mem_q[b_bidx] <= bus.b_data_i;
        end
        if (a_wr) begin
            mem_q[a_bidx][a_lane*AWidth +: AWidth] <= bus.a_data_i;
        end
    end

    // Stage p1: first output register, status pulses
    logic [AWidth-1:0] a_data_p1_q;
    logic [BWidth-1:0] b_data_p1_q;
    logic              a_vld_p1_q, b_vld_p1_q;
    logic              collision_q, oob_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_data_p1_q <= '0;
            b_data_p1_q <= '0;
            a_vld_p1_q  <= 1'b0;
            b_vld_p1_q  <= 1'b0;
            collision_q <= 1'b0;
            oob_q       <= 1'b0;
        end else begin
            a_vld_p1_q  <= a_acc;
            b_vld_p1_q  <= b_acc;
            collision_q <= collision_d;
            oob_q       <= oob_d;
            if (a_acc) begin
                a_data_p1_q <= a_rd_d;
            end
            if (b_acc) begin
                b_data_p1_q <= b_rd_d;
            end
        end
    end

    assign bus.collision_o = collision_q;
    assign bus.oob_o       = oob_q;

    generate
        if (ReadLatency == 2) begin : g_lat2
            logic [AWidth-1:0] a_data_p2_q;
            logic [BWidth-1:0] b_data_p2_q;
            logic              a_vld_p2_q, b_vld_p2_q;

            // Stage p2: extra output register for the two-cycle latency
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_data_p2_q <= '0;
                    b_data_p2_q <= '0;
                    a_vld_p2_q  <= 1'b0;
                    b_vld_p2_q  <= 1'b0;
                end else begin
                    a_data_p2_q <= a_data_p1_q;
                    b_data_p2_q <= b_data_p1_q;
                    a_vld_p2_q  <= a_vld_p1_q;
                    b_vld_p2_q  <= b_vld_p1_q;
                end
            end

            assign bus.a_data_o  = a_data_p2_q;
            assign bus.b_data_o  = b_data_p2_q;
            assign bus.a_valid_o = a_vld_p2_q;
            assign bus.b_valid_o = b_vld_p2_q;
        end else begin : g_lat1
            assign bus.a_data_o  = a_data_p1_q;
            assign bus.b_data_o  = b_data_p1_q;
            assign bus.a_valid_o = a_vld_p1_q;
            assign bus.b_valid_o = b_vld_p1_q;
        end
    endgenerate
endmodule

// File: doc/mixed_width_dp_bram.md
# mixed_width_dp_bram

True dual-port block RAM with asymmetric port widths: port A is a narrow word port and port B is a wide port covering `Ratio` consecutive A words. It adds registered read-valid outputs, a selectable read latency, cross-port collision and out-of-range detection, and an optional post-reset clear sweep. It serves as the shared buffer between narrow producers (pixel and weight loaders) and wide consumers (MAC arrays) in the accelerator datapath.

## Interface
- `AWidth`, 8, port A data width in bits
- `Ratio`, 4, A words per B word; B data width is `AWidth*Ratio`; power of two, ≥1
- `Depth`, 1024, capacity in A words; multiple of `Ratio`; B depth is `Depth/Ratio`
- `ReadLatency`, 1, read latency in cycles; legal values are 1 and 2
- `clk_i` in 1: single clock, rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `a_en_i` in 1: port A access request
- `a_write_en_i` in 1: port A write when `a_en_i`=1
- `a_addr_i` in `$clog2(Depth)+1`: port A word address
- `a_data_i` in `AWidth`: port A write data
- `a_data_o` out `AWidth`: port A read data
- `a_valid_o` out 1: `a_data_o` valid
- `b_en_i`, `b_write_en_i` in 1 each: port B request and write
- `b_addr_i` in `$clog2(Depth/Ratio)+1`: port B word address
- `b_data_i` in `AWidth*Ratio`: port B write data
- `b_data_o` out `AWidth*Ratio`: port B read data
- `b_valid_o` out 1: `b_data_o` valid
- `busy_o` out 1: clear sweep in progress; requests are ignored
- `collision_o` out 1: one-cycle pulse, cross-port conflict
- `oob_o` out 1: one-cycle pulse, out-of-range access on either port

## Operation
- Storage is `Depth/Ratio` words of `AWidth*Ratio` bits. A word `n` maps to B word `n/Ratio`, lane `n%Ratio`, at bits `[lane*AWidth +: AWidth]`. Lane 0 is the LSB lane.
- An access is accepted when `en`=1 and `busy_o`=0. Every accepted access, read or write, produces exactly one valid pulse on that port after `ReadLatency` cycles.
- Within a port, reads are write-first: an accepted write returns the written data on `data_o`.
- Across ports, reads are read-first: a read sees memory contents from before any same-cycle write by the other port.
- A collision occurs when both ports are accepted in the same cycle, their address ranges overlap (A word inside the B word), and at least one port writes. On a write/write collision, port A wins its lane and port B writes the remaining lanes. `collision_o` pulses.
- Out of range means A address ≥ `Depth` or B address ≥ `Depth/Ratio`.
  - The access is still accepted and valid still pulses.
  - Writes are dropped and read data is 0.
  - `oob_o` pulses.
  - Out-of-range accesses never count as collisions.
- Clear FSM states: CLEAR, READY.
  - `rst_i` forces CLEAR with the sweep counter at 0.
  - CLEAR writes 0 to one B word per cycle.
  - After B word `Depth/Ratio-1` is written, the FSM moves to READY.
  - `rst_i` asserted mid-sweep restarts the sweep at 0.

## Timing
- Reset values: `a_data_o`=0, `b_data_o`=0, `a_valid_o`=0, `b_valid_o`=0, `collision_o`=0, `oob_o`=0, and every pipeline stage is 0. `busy_o`=1 when the clear feature is compiled in, 0 otherwise.
- `ReadLatency`=1: data and valid are registered at the edge that samples the request.
- `ReadLatency`=2: adds one output register stage; data and valid appear one cycle later.
- `collision_o` and `oob_o` are registered and appear one cycle after the request, independent of `ReadLatency`.
- `busy_o` deasserts exactly `Depth/Ratio` cycles after the first edge with `rst_i`=0. Requests are accepted in that same cycle.
- Back-to-back accesses are supported on both ports at full rate.

## Configuration
- Macro: `MIXED_WIDTH_DP_BRAM_CLEAR_EN`.
- Defined: the clear FSM is present and memory reads 0 after the sweep completes.
- Undefined: no FSM, `busy_o` is tied 0, requests are accepted on the first cycle after reset, and memory contents after reset are unspecified (X in simulation).

## Test plan
All scenarios use `AWidth`=8, `Ratio`=4, `Depth`=16, `ReadLatency`=1, with the clear feature compiled in.
1. Release `rst_i`, then poll → `busy_o` is high for 4 cycles; an A read of address 5 after that returns 0x00 with `a_valid_o` pulsing one cycle later.
2. A writes 0x11, 0x22, 0x33, 0x44 to addresses 4–7 → each write echoes on `a_data_o`; a B read of address 1 returns 0x44332211.
3. B writes 0xDEADBEEF to address 2 → A reads of addresses 8–11 return 0xEF, 0xBE, 0xAD, 0xDE.
4. In the same cycle, A writes 0x55 to address 9 and B writes 0x01020304 to address 2 → `collision_o` pulses once; a later B read of address 2 returns 0x01025504.
5. A reads address 16, then A writes 0x77 to address 20 → each access pulses `oob_o` and `a_valid_o`; the read returns 0x00; all in-range contents are unchanged.
6. Assert `rst_i` for one cycle on sweep cycle 2 → `busy_o` stays high for 4 full cycles after the release; a B write attempted during the sweep is ignored, with no valid pulse and memory reading 0.
